// File: rtl/cluster_cache_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cluster_cache_pkg : shared types and widths for the cluster cache front end
// Rev 1.0
// ----------------------------------------------------------------------------
package cluster_cache_pkg;

  localparam int unsigned DEF_TID_WIDTH      = 6;
  localparam int unsigned DEF_SID_WIDTH      = 3;
  localparam int unsigned DEF_BLOCK_IDX_BITS = 4;

  typedef logic [DEF_SID_WIDTH-1:0] unit_idx_t;

  function automatic int unsigned data_width(input int unsigned block_idx_bits);
    return 8 * (1 << block_idx_bits);
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = data_width(DEF_BLOCK_IDX_BITS);
  localparam int unsigned DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_lzc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter_lzc : combinational round-robin grant, first eligible at/after ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter_lzc
  import cluster_cache_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  unit_idx_t          i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output unit_idx_t          o_grant_idx,
  output logic               o_any
);

  // Walk the rotated vector from the far end so the candidate nearest ptr wins.
  always_comb begin
    int w_idx;
    w_idx       = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_eligible[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = unit_idx_t'(w_idx);
        o_any          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cluster_cache_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cluster_cache_req_arbiter : merges unit request streams onto one cache port
// Rev 1.0
// ----------------------------------------------------------------------------
module cluster_cache_req_arbiter
  import cluster_cache_pkg::*;
#(
  parameter  int NUM_UNITS       = 4,
  parameter  int ADDRESS_WIDTH   = 32,
  parameter  int BLOCK_IDX_BITS  = DEF_BLOCK_IDX_BITS,
  parameter  int TID_WIDTH       = DEF_TID_WIDTH,
  parameter  int SID_WIDTH       = DEF_SID_WIDTH,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int DATA_WIDTH      = int'(data_width(BLOCK_IDX_BITS)),
  localparam int BE_WIDTH        = DATA_WIDTH / 8,
  localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_UNITS-1:0]            unit_req_valid_i,
  output logic [NUM_UNITS-1:0]            unit_req_ready_o,
  input  logic [NUM_UNITS*ADDRESS_WIDTH-1:0] unit_req_addr_i,
  input  logic [NUM_UNITS-1:0]            unit_req_we_i,
  input  logic [NUM_UNITS*BE_WIDTH-1:0]   unit_req_be_i,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_req_wdata_i,
  input  logic [NUM_UNITS*TID_WIDTH-1:0]  unit_req_tid_i,
  output logic [NUM_UNITS-1:0]            unit_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           unit_rsp_data_o,
  output logic [TID_WIDTH-1:0]            unit_rsp_tid_o,
  output logic                            unit_rsp_error_o,
  output logic                            cache_req_valid_o,
  input  logic                            cache_req_ready_i,
  output logic [ADDRESS_WIDTH-1:0]        cache_req_addr_o,
  output logic                            cache_req_we_o,
  output logic [BE_WIDTH-1:0]             cache_req_be_o,
  output logic [DATA_WIDTH-1:0]           cache_req_wdata_o,
  output logic [SID_WIDTH-1:0]            cache_req_sid_o,
  output logic [TID_WIDTH-1:0]            cache_req_tid_o,
  input  logic                            cache_rsp_valid_i,
  input  logic [SID_WIDTH-1:0]            cache_rsp_sid_i,
  input  logic [TID_WIDTH-1:0]            cache_rsp_tid_i,
  input  logic [DATA_WIDTH-1:0]           cache_rsp_data_i,
  input  logic                            cache_rsp_error_i,
  output logic                            idle_o
);

  logic [CNT_WIDTH-1:0]     r_cnt [NUM_UNITS];
  unit_idx_t                r_ptr;
  logic                     r_req_valid;
  logic [ADDRESS_WIDTH-1:0] r_req_addr;
  logic                     r_req_we;
  logic [BE_WIDTH-1:0]      r_req_be;
  logic [DATA_WIDTH-1:0]    r_req_wdata;
  logic [SID_WIDTH-1:0]     r_req_sid;
  logic [TID_WIDTH-1:0]     r_req_tid;
  logic [NUM_UNITS-1:0]     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic [TID_WIDTH-1:0]     r_rsp_tid;
  logic                     r_rsp_err;

  logic [NUM_UNITS-1:0]     w_elig;
  logic [NUM_UNITS-1:0]     w_grant;
  logic [NUM_UNITS-1:0]     w_dec;
  unit_idx_t                w_gidx;
  logic                     w_any;
  logic                     w_load_en;
  logic                     w_cnt_zero;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic                     w_sel_we;
  logic [BE_WIDTH-1:0]      w_sel_be;
  logic [DATA_WIDTH-1:0]    w_sel_wdata;
  logic [TID_WIDTH-1:0]     w_sel_tid;

  // A response only retires a request when its unit actually has one in flight.
  always_comb begin
    w_elig     = '0;
    w_dec      = '0;
    w_cnt_zero = 1'b1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_elig[i] = unit_req_valid_i[i] && (r_cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      w_dec[i]  = cache_rsp_valid_i && (cache_rsp_sid_i == SID_WIDTH'(i)) && (r_cnt[i] != '0);
      if (r_cnt[i] != '0) w_cnt_zero = 1'b0;
    end
  end

  rr_arbiter_lzc #(
    .NUM_REQ (NUM_UNITS)
  ) u_rr (
    .i_eligible  (w_elig),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  assign w_load_en        = !r_req_valid || cache_req_ready_i;
  assign unit_req_ready_o = w_load_en ? w_grant : '0;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    w_sel_tid   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = unit_req_addr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_we    = unit_req_we_i[i];
        w_sel_be    = unit_req_be_i[i*BE_WIDTH +: BE_WIDTH];
        w_sel_wdata = unit_req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_tid   = unit_req_tid_i[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_be    <= '0;
      r_req_wdata <= '0;
      r_req_sid   <= '0;
      r_req_tid   <= '0;
    end else if (w_load_en) begin
      r_req_valid <= w_any;
      if (w_any) begin
        r_req_addr  <= w_sel_addr;
        r_req_we    <= w_sel_we;
        r_req_be    <= w_sel_be;
        r_req_wdata <= w_sel_wdata;
        r_req_sid   <= SID_WIDTH'(w_gidx);
        r_req_tid   <= w_sel_tid;
        r_ptr       <= (int'(w_gidx) == NUM_UNITS - 1) ? '0 : w_gidx + unit_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_UNITS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        case ({unit_req_ready_o[i], w_dec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_tid   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_dec;
      if (cache_rsp_valid_i) begin
        r_rsp_data <= cache_rsp_data_i;
        r_rsp_tid  <= cache_rsp_tid_i;
        r_rsp_err  <= cache_rsp_error_i;
      end
    end
  end

  // Stray responses (unknown unit or nothing in flight) are dropped.
  a_rsp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cache_rsp_valid_i |-> (|w_dec));

  assign cache_req_valid_o = r_req_valid;
  assign cache_req_addr_o  = r_req_addr;
  assign cache_req_we_o    = r_req_we;
  assign cache_req_be_o    = r_req_be;
  assign cache_req_wdata_o = r_req_wdata;
  assign cache_req_sid_o   = r_req_sid;
  assign cache_req_tid_o   = r_req_tid;
  assign unit_rsp_valid_o  = r_rsp_valid;
  assign unit_rsp_data_o   = r_rsp_data;
  assign unit_rsp_tid_o    = r_rsp_tid;
  assign unit_rsp_error_o  = r_rsp_err;
  assign idle_o            = !r_req_valid && w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_cluster_cache_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cluster_cache_req_arbiter : randomized bench against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cluster_cache_req_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int BEW = 16;
  localparam int TW  = 6;
  localparam int SW  = 3;
  localparam int MAX = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      unit_req_valid_i;
  logic [N-1:0]      unit_req_ready_o;
  logic [N*AW-1:0]   unit_req_addr_i;
  logic [N-1:0]      unit_req_we_i;
  logic [N*BEW-1:0]  unit_req_be_i;
  logic [N*DW-1:0]   unit_req_wdata_i;
  logic [N*TW-1:0]   unit_req_tid_i;
  logic [N-1:0]      unit_rsp_valid_o;
  logic [DW-1:0]     unit_rsp_data_o;
  logic [TW-1:0]     unit_rsp_tid_o;
  logic              unit_rsp_error_o;
  logic              cache_req_valid_o;
  logic              cache_req_ready_i;
  logic [AW-1:0]     cache_req_addr_o;
  logic              cache_req_we_o;
  logic [BEW-1:0]    cache_req_be_o;
  logic [DW-1:0]     cache_req_wdata_o;
  logic [SW-1:0]     cache_req_sid_o;
  logic [TW-1:0]     cache_req_tid_o;
  logic              cache_rsp_valid_i;
  logic [SW-1:0]     cache_rsp_sid_i;
  logic [TW-1:0]     cache_rsp_tid_i;
  logic [DW-1:0]     cache_rsp_data_i;
  logic              cache_rsp_error_i;
  logic              idle_o;

  always #5 clk_i = ~clk_i;

  cluster_cache_req_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .unit_req_valid_i  (unit_req_valid_i),
    .unit_req_ready_o  (unit_req_ready_o),
    .unit_req_addr_i   (unit_req_addr_i),
    .unit_req_we_i     (unit_req_we_i),
    .unit_req_be_i     (unit_req_be_i),
    .unit_req_wdata_i  (unit_req_wdata_i),
    .unit_req_tid_i    (unit_req_tid_i),
    .unit_rsp_valid_o  (unit_rsp_valid_o),
    .unit_rsp_data_o   (unit_rsp_data_o),
    .unit_rsp_tid_o    (unit_rsp_tid_o),
    .unit_rsp_error_o  (unit_rsp_error_o),
    .cache_req_valid_o (cache_req_valid_o),
    .cache_req_ready_i (cache_req_ready_i),
    .cache_req_addr_o  (cache_req_addr_o),
    .cache_req_we_o    (cache_req_we_o),
    .cache_req_be_o    (cache_req_be_o),
    .cache_req_wdata_o (cache_req_wdata_o),
    .cache_req_sid_o   (cache_req_sid_o),
    .cache_req_tid_o   (cache_req_tid_o),
    .cache_rsp_valid_i (cache_rsp_valid_i),
    .cache_rsp_sid_i   (cache_rsp_sid_i),
    .cache_rsp_tid_i   (cache_rsp_tid_i),
    .cache_rsp_data_i  (cache_rsp_data_i),
    .cache_rsp_error_i (cache_rsp_error_i),
    .idle_o            (idle_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Unit-side request state: a unit keeps its request until granted.
  bit            u_v   [N];
  logic [AW-1:0] u_addr[N];
  logic          u_we  [N];
  logic [BEW-1:0] u_be [N];
  logic [DW-1:0] u_wd  [N];
  logic [TW-1:0] u_tid [N];

  // Reference model state.
  int            m_cnt [N];
  int            m_ptr;
  bit            m_valid;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BEW-1:0] m_be;
  logic [DW-1:0] m_wd;
  int            m_sid;
  logic [TW-1:0] m_tid;
  logic [N-1:0]  m_rsp_v;
  logic [DW-1:0] m_rsp_data;
  logic [TW-1:0] m_rsp_tid;
  logic          m_rsp_err;

  typedef struct { int sid; logic [TW-1:0] tid; } inflight_t;
  inflight_t outq[$];
  int        sidq[$];
  bit        use_dead = 1'b0;

  function automatic logic [DW-1:0] rand_dw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_units();
    for (int i = 0; i < N; i++) begin
      unit_req_valid_i[i]          = u_v[i];
      unit_req_addr_i[i*AW +: AW]  = u_addr[i];
      unit_req_we_i[i]             = u_we[i];
      unit_req_be_i[i*BEW +: BEW]  = u_be[i];
      unit_req_wdata_i[i*DW +: DW] = u_wd[i];
      unit_req_tid_i[i*TW +: TW]   = u_tid[i];
    end
  endtask

  task automatic check_state();
    bit exp_idle;
    exp_idle = !m_valid;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_idle = 1'b0;
    check_eq("req_valid", DW'(cache_req_valid_o), DW'(m_valid));
    if (m_valid) begin
      check_eq("req_addr",  DW'(cache_req_addr_o),  DW'(m_addr));
      check_eq("req_we",    DW'(cache_req_we_o),    DW'(m_we));
      check_eq("req_be",    DW'(cache_req_be_o),    DW'(m_be));
      check_eq("req_wdata", cache_req_wdata_o,      m_wd);
      check_eq("req_sid",   DW'(cache_req_sid_o),   DW'(m_sid));
      check_eq("req_tid",   DW'(cache_req_tid_o),   DW'(m_tid));
    end
    check_eq("rsp_valid", DW'(unit_rsp_valid_o), DW'(m_rsp_v));
    if (m_rsp_v != '0) begin
      check_eq("rsp_data", unit_rsp_data_o,        m_rsp_data);
      check_eq("rsp_tid",  DW'(unit_rsp_tid_o),    DW'(m_rsp_tid));
      check_eq("rsp_err",  DW'(unit_rsp_error_o),  DW'(m_rsp_err));
    end
    check_eq("idle", DW'(idle_o), DW'(exp_idle));
  endtask

  // One clock: drive at the negedge, check ready, advance model, check state.
  task automatic step(input int pv, input int pr, input int pp);
    int g, rs, idx, k;
    bit le, rsp;
    logic [N-1:0] exp_rdy;
    logic [TW-1:0] rtid;
    for (int i = 0; i < N; i++) begin
      if (!u_v[i] && ($urandom_range(99) < pv)) begin
        u_v[i]    = 1'b1;
        u_addr[i] = $urandom & ~32'hF;
        u_we[i]   = 1'($urandom_range(1));
        u_be[i]   = BEW'($urandom);
        u_wd[i]   = rand_dw();
        u_tid[i]  = TW'($urandom);
      end
    end
    drive_units();
    cache_req_ready_i = ($urandom_range(99) < pr);
    rsp = 1'b0; rs = 0; rtid = '0;
    if (outq.size() > 0 && ($urandom_range(99) < pp)) begin
      k    = $urandom_range(outq.size() - 1);
      rs   = outq[k].sid;
      rtid = outq[k].tid;
      outq.delete(k);
      rsp  = 1'b1;
    end
    cache_rsp_valid_i = rsp;
    cache_rsp_sid_i   = SW'(rs);
    cache_rsp_tid_i   = rtid;
    cache_rsp_data_i  = use_dead ? DW'(16'hDEAD) : rand_dw();
    cache_rsp_error_i = 1'($urandom_range(1));
    #1;
    le = !m_valid || cache_req_ready_i;
    g  = -1;
    for (int j = 0; j < N; j++) begin
      idx = (m_ptr + j) % N;
      if (g < 0 && u_v[idx] && m_cnt[idx] < MAX) g = idx;
    end
    exp_rdy = '0;
    if (le && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("unit_ready", DW'(unit_req_ready_o), DW'(exp_rdy));
    if (m_valid && cache_req_ready_i) begin
      outq.push_back('{m_sid, m_tid});
      sidq.push_back(m_sid);
    end
    if (le) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_addr  = u_addr[g];
        m_we    = u_we[g];
        m_be    = u_be[g];
        m_wd    = u_wd[g];
        m_tid   = u_tid[g];
        m_sid   = g;
        m_ptr   = (g + 1) % N;
        m_cnt[g]++;
        u_v[g]  = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_rsp_v = '0;
    if (rsp) begin
      m_rsp_v[rs] = 1'b1;
      m_cnt[rs]--;
      m_rsp_data  = cache_rsp_data_i;
      m_rsp_tid   = rtid;
      m_rsp_err   = cache_rsp_error_i;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_state();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < N; i++) begin
      u_v[i] = 1'b0; u_addr[i] = '0; u_we[i] = 1'b0;
      u_be[i] = '0; u_wd[i] = '0; u_tid[i] = '0;
      m_cnt[i] = 0;
    end
    drive_units();
    cache_req_ready_i = 1'b0;
    cache_rsp_valid_i = 1'b0;
    cache_rsp_sid_i   = '0;
    cache_rsp_tid_i   = '0;
    cache_rsp_data_i  = '0;
    cache_rsp_error_i = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_rsp_v = '0;
    outq.delete();
    sidq.delete();
    repeat (2) @(negedge clk_i);
    check_eq("rst_req_valid", DW'(cache_req_valid_o), '0);
    check_eq("rst_req_addr",  DW'(cache_req_addr_o),  '0);
    check_eq("rst_req_sid",   DW'(cache_req_sid_o),   '0);
    check_eq("rst_rsp_valid", DW'(unit_rsp_valid_o),  '0);
    check_eq("rst_idle",      DW'(idle_o),            DW'(1));
    rst_ni = 1'b1;
  endtask

  initial begin
    int exp_seq[5];
    int guard;
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();

    // Single load from unit 0, then its response.
    u_v[0] = 1'b1; u_addr[0] = 32'h100; u_we[0] = 1'b0;
    u_be[0] = '0; u_wd[0] = '0; u_tid[0] = 6'd5;
    step(0, 100, 0);
    check_eq("d1_valid", DW'(cache_req_valid_o), DW'(1));
    check_eq("d1_sid",   DW'(cache_req_sid_o),   DW'(0));
    check_eq("d1_tid",   DW'(cache_req_tid_o),   DW'(5));
    check_eq("d1_addr",  DW'(cache_req_addr_o),  DW'(32'h100));
    step(0, 100, 0);
    use_dead = 1'b1;
    step(0, 100, 100);
    use_dead = 1'b0;
    check_eq("d1_rsp_valid", DW'(unit_rsp_valid_o), DW'(4'b0001));
    check_eq("d1_rsp_data",  unit_rsp_data_o,       DW'(16'hDEAD));
    check_eq("d1_idle",      DW'(idle_o),           DW'(1));

    // All units requesting continuously: round-robin order from unit 0.
    do_reset();
    repeat (8) step(100, 100, 100);
    check_eq("rr_count", DW'(sidq.size() >= 5), DW'(1));
    if (sidq.size() >= 5)
      for (int i = 0; i < 5; i++) check_eq("rr_order", DW'(sidq[i]), DW'(exp_seq[i]));

    // Outstanding limit: no responses until every unit saturates.
    do_reset();
    repeat (24) step(100, 100, 0);
    check_eq("limit_ready", DW'(unit_req_ready_o), '0);
    check_eq("limit_idle",  DW'(idle_o),           '0);
    repeat (4) step(100, 100, 100);

    // Randomized phases with varying request, acceptance and response rates.
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pr, pp;
      pv = $urandom_range(100, 20);
      pr = $urandom_range(100, 20);
      pp = $urandom_range(100, 10);
      repeat (250) step(pv, pr, pp);
    end

    // Asynchronous reset mid-stream.
    repeat (10) step(100, 40, 20);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid", DW'(cache_req_valid_o), '0);
    check_eq("mid_rst_rsp",   DW'(unit_rsp_valid_o),  '0);
    check_eq("mid_rst_idle",  DW'(idle_o),            DW'(1));
    do_reset();
    repeat (3) step(100, 100, 100);
    check_eq("post_rst_count", DW'(sidq.size() >= 1), DW'(1));
    if (sidq.size() >= 1) check_eq("post_rst_first", DW'(sidq[0]), '0);

    // Drain everything and confirm idle.
    guard = 0;
    while ((outq.size() > 0 || m_valid) && guard < 300) begin
      step(0, 100, 100);
      guard++;
    end
    check_eq("drain_done", DW'(guard < 300), DW'(1));
    check_eq("drain_idle", DW'(idle_o),      DW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
